// File: rtl/lcd_host.sv
// LCD host: command FIFO feeding an image-processing controller, a 64x8 image ROM
// with a preload port, and a 64x8 result buffer with write counter and readback.
module lcd_host #(
    parameter int QDEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] q_cmd,
    input  logic       q_push,
    output logic       q_full,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       busy,
    input  logic       done,
    input  logic       IROM_EN,
    input  logic [5:0] IROM_A,
    output logic [7:0] IROM_Q,
    input  logic       IRB_RW,
    input  logic [5:0] IRB_A,
    input  logic [7:0] IRB_D,
    input  logic       rom_we,
    input  logic [5:0] rom_wa,
    input  logic [7:0] rom_wd,
    input  logic [5:0] rd_a,
    output logic [7:0] rd_q,
    output logic       frame_valid,
    output logic [7:0] wr_cnt
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

    state_t          state_reg;
    logic [2:0]      q_mem [QDEPTH];
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            push;
    logic            pop;
    logic            q_empty;

    logic [7:0]      rom_mem [64];
    logic [7:0]      irb_mem [64];

    // DONE forces full so the queue contents stay frozen after the frame completes.
    assign q_full  = (count_reg == CW'(QDEPTH)) || (state_reg == DONE);
    assign q_empty = (count_reg == '0);
    assign push    = q_push && !q_full;
    assign pop     = (state_reg == ISSUE);

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr_reg] <= q_cmd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Issue decisions use the registered count, so a freshly pushed entry waits an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cmd         <= 3'd0;
            cmd_valid   <= 1'b0;
            frame_valid <= 1'b0;
        end else if (done) begin
            state_reg   <= DONE;
            cmd_valid   <= 1'b0;
            frame_valid <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!busy && !q_empty) begin
                        state_reg <= ISSUE;
                        cmd       <= q_mem[rd_ptr_reg];
                        cmd_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_reg <= GAP;
                    cmd_valid <= 1'b0;
                end
                GAP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= DONE;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rom_we) begin
            rom_mem[rom_wa] <= rom_wd;
        end
    end

    // Non-blocking read alongside the preload write returns the old word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IROM_Q <= 8'd0;
        end else if (!IROM_EN) begin
            IROM_Q <= rom_mem[IROM_A];
        end
    end

    always_ff @(posedge clk) begin
        if (!IRB_RW) begin
            irb_mem[IRB_A] <= IRB_D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt <= 8'd0;
        end else if (!IRB_RW && (wr_cnt != 8'hFF)) begin
            wr_cnt <= wr_cnt + 8'd1;
        end
    end

    assign rd_q = irb_mem[rd_a];

endmodule

// File: doc/lcd_host.md
LCD_HOST -- requirements
Module: lcd_host

Interface
REQ-001 Parameter QDEPTH, default 4, command queue depth (power of 2, >=2).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 q_cmd  input  3  command opcode to enqueue (0 WRITE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 AVG, 6 MX, 7 MY).
REQ-005 q_push  input  1  enqueue strobe for q_cmd.
REQ-006 q_full  output  1  queue full, or host in DONE; pushes are ignored.
REQ-007 cmd  output  3  opcode to controller.
REQ-008 cmd_valid  output  1  command strobe to controller.
REQ-009 busy  input  1  controller busy.
REQ-010 done  input  1  controller finished.
REQ-011 IROM_EN  input  1  image ROM read enable, active-low.
REQ-012 IROM_A  input  6  image ROM address.
REQ-013 IROM_Q  output  8  image ROM read data.
REQ-014 IRB_RW  input  1  result buffer access, 0 = write.
REQ-015 IRB_A  input  6  result buffer address.
REQ-016 IRB_D  input  8  result buffer write data.
REQ-017 rom_we, rom_wa[5:0], rom_wd[7:0]  input  1/6/8  ROM preload port.
REQ-018 rd_a  input  6; rd_q  output  8  combinational result buffer readback, rd_q = buf[rd_a].
REQ-019 frame_valid  output  1  sticky; set when done is seen.
REQ-020 wr_cnt  output  8  count of IRB writes since reset.

Function
REQ-021 Command queue: FIFO of QDEPTH 3-bit entries.
- Push occurs when q_push=1 and q_full=0.
- Pop occurs in ISSUE.
- Full/empty is evaluated from the count before this edge: a push while full is dropped even if a pop happens on the same edge.
- Push and pop on the same edge when neither full nor empty leaves the count unchanged.
REQ-022 FSM states IDLE, ISSUE, GAP, DONE; reset state is IDLE.
REQ-023 IDLE -> ISSUE when busy=0, done=0 and queue non-empty (registered count); otherwise stay in IDLE.
REQ-024 ISSUE:
- cmd_valid=1 for exactly one cycle, with cmd = queue head.
- The head is popped.
- Next state is GAP.
REQ-025 GAP: cmd_valid=0 for one cycle so the controller's busy response is visible; then -> IDLE.
REQ-026 Any state -> DONE when done=1 (highest priority).
- DONE is absorbing until reset.
- On entry, frame_valid=1 and cmd_valid=0.
- q_full is held at 1; queue contents are frozen.
REQ-027 cmd_valid is never 1 in two consecutive cycles and never 1 in a cycle in which the state was entered with busy=1.
REQ-028 An entry pushed on the same edge that the queue becomes non-empty is issued no earlier than the following edge.
REQ-029 Image ROM read:
- 64x8 storage.
- On each rising edge with IROM_EN=0, IROM_Q <= rom[IROM_A].
- With IROM_EN=1, IROM_Q holds its value.
- Read latency is 1 cycle.
REQ-030 ROM preload: rom[rom_wa] <= rom_wd on an edge with rom_we=1. A same-edge read of the same address returns the old data.
REQ-031 Result buffer write:
- 64x8 storage.
- On a rising edge with IRB_RW=0, buf[IRB_A] <= IRB_D and wr_cnt increments, saturating at 255.
- IRB_RW=1 causes no write.
REQ-032 ROM and result buffer contents are not reset; readback of never-written locations is undefined.

Reset
REQ-033 While reset=0, asynchronously:
- state=IDLE, queue emptied.
- cmd=0, cmd_valid=0, IROM_Q=0.
- frame_valid=0, wr_cnt=0, q_full=0.
REQ-034 Reset asserted mid-operation (any state, including ISSUE) drops the in-flight command and all queued commands; no cmd_valid pulse occurs while reset=0 or on the first edge after release.

Verification
REQ-035 Push WRITE, RIGHT, AVG with busy=0 -> three single-cycle cmd_valid pulses with cmd=0, 4, 5, spaced by at least 2 cycles.
REQ-036 Push UP; hold busy=1 for 10 cycles, then drop it -> no cmd_valid while busy=1; cmd_valid=1, cmd=1 within 1 cycle after busy falls.
REQ-037 Push 5 commands with QDEPTH=4 and busy=1 -> q_full=1 after the 4th push; the 5th is dropped; exactly 4 commands are issued once busy falls.
REQ-038 Preload rom[i]=i+8'h10; drive IROM_EN=0 and IROM_A=0..63 -> IROM_Q equals 8'h10+A one cycle later; IROM_EN=1 holds IROM_Q.
REQ-039 Drive 64 writes IRB_RW=0, IRB_A=k, IRB_D=~k, then done=1 -> wr_cnt=64; rd_q at rd_a=k equals ~k; frame_valid=1; q_full=1; pushes ignored.
REQ-040 Pull reset low during ISSUE with 3 commands queued -> cmd_valid=0 immediately; after release, no pulse until a new push.
